// File: rtl/byte_ram_pkg.sv
// Shared constants for the handshake byte RAM: access sizes, FSM encoding, RW polarity.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package byte_ram_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Number of bytes touched by an access of the given size; reserved touches none.
  function automatic int size_bytes(input logic [1:0] size);
    case (size)
      SZ_BYTE: size_bytes = 1;
      SZ_HALF: size_bytes = 2;
      SZ_WORD: size_bytes = 4;
      default: size_bytes = 0;
    endcase
  endfunction

endpackage

// File: rtl/byte_ram_hs_if.sv
// MOV/MOC memory bus between the control unit (master) and the RAM (slave).
// Latency: n/a (wiring only).
// Backpressure: master holds MOV and its request fields until MOC is seen.
interface byte_ram_hs_if #(
  parameter int ADDR_W = 8
) ();
  logic              MOV;
  logic              RW;
  logic [1:0]        typeData;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       din;
  logic [31:0]       dout;
  logic              MOC;
  logic              fault;

  modport master (
    output MOV, RW, typeData, addr, din,
    input  dout, MOC, fault
  );

  modport slave (
    input  MOV, RW, typeData, addr, din,
    output dout, MOC, fault
  );
endinterface

// File: rtl/byte_ram_lane_pack.sv
// Big-endian lane mapping: lane i addresses byte A+i; packs din into lanes, unpacks lanes to dout.
// Latency: combinational.
// Backpressure: none.
module byte_ram_lane_pack
  import byte_ram_pkg::*;
(
  input  logic [1:0]       size,
  input  logic [31:0]      din,
  input  logic [3:0][7:0]  rd_b,
  output logic [3:0]       lane_en,
  output logic [3:0][7:0]  wr_b,
  output logic [31:0]      rd_dat
);

  // Lane 0 carries the most significant used byte; unused upper read bits stay zero.
  always_comb begin
    int n;
    n       = size_bytes(size);
    lane_en = '0;
    wr_b    = '0;
    rd_dat  = '0;
    for (int i = 0; i < 4; i++) begin
      if (i < n) begin
        lane_en[i] = 1'b1;
        wr_b[i]    = 8'(din >> (8 * (n - 1 - i)));
        rd_dat     = {rd_dat[23:0], rd_b[i]};
      end
    end
  end

endmodule

// File: rtl/byte_ram_hs.sv
// Byte-addressed RAM behind a MOV/MOC handshake with WAIT_CYCLES wait states; BYTE_RAM_ALIGN_CHK_EN faults unaligned half/word.
// Latency: MOC rises WAIT_CYCLES+1 edges after the edge that captures MOV.
// Backpressure: one access per MOV high phase; MOC held until MOV drops, then clears on that edge.
module byte_ram_hs
  import byte_ram_pkg::*;
#(
  parameter int DEPTH       = 256,
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic         CLK,
  input  logic         CLR,
  byte_ram_hs_if.slave bus
);

  logic [7:0] mem [0:DEPTH-1];

  state_t            state;
  logic [3:0]        cnt;
  logic              cap_rw;
  logic [1:0]        cap_size;
  logic [ADDR_W-1:0] cap_addr;
  logic [31:0]       cap_din;
  logic              moc_q;
  logic              fault_q;
  logic [31:0]       dout_q;

  logic [3:0][7:0]   rd_b;
  logic [3:0][7:0]   wr_b;
  logic [3:0]        lane_en;
  logic [3:0]        wr_lane;
  logic [31:0]       rd_dat;
  logic              misalign;
  logic              flt;
  logic              do_access;

`ifdef BYTE_RAM_ALIGN_CHK_EN
  assign misalign = ((cap_size == SZ_HALF) && cap_addr[0]) ||
                    ((cap_size == SZ_WORD) && (cap_addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  assign flt       = (cap_size == SZ_RSVD) || misalign;
  // The access happens only on the edge that enters DONE; reset forces IDLE so it can never fire mid-reset.
  assign do_access = (state == ST_BUSY) && (cnt == 4'd0);
  assign wr_lane   = lane_en & {4{do_access && (cap_rw == RW_WRITE) && !flt}};

  // Fetch the four consecutive bytes at the captured address, wrapping modulo DEPTH.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      rd_b[i] = mem[cap_addr + ADDR_W'(i)];
    end
  end

  byte_ram_lane_pack u_lane_pack (
    .size    (cap_size),
    .din     (cap_din),
    .rd_b    (rd_b),
    .lane_en (lane_en),
    .wr_b    (wr_b),
    .rd_dat  (rd_dat)
  );

  // Storage is not reset; all enabled lanes commit together on the access edge.
  always_ff @(posedge CLK) begin
    for (int i = 0; i < 4; i++) begin
      if (wr_lane[i]) mem[cap_addr + ADDR_W'(i)] <= wr_b[i];
    end
  end

  // Handshake FSM; counter is loaded with WAIT_CYCLES so completion lands WAIT_CYCLES+1 edges after capture.
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      state    <= ST_IDLE;
      cnt      <= 4'd0;
      cap_rw   <= RW_READ;
      cap_size <= SZ_BYTE;
      cap_addr <= '0;
      cap_din  <= '0;
      moc_q    <= 1'b0;
      fault_q  <= 1'b0;
      dout_q   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.MOV) begin
            cap_rw   <= bus.RW;
            cap_size <= bus.typeData;
            cap_addr <= bus.addr;
            cap_din  <= bus.din;
            cnt      <= 4'(WAIT_CYCLES);
            state    <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (cnt == 4'd0) begin
            state   <= ST_DONE;
            moc_q   <= 1'b1;
            fault_q <= flt;
            if ((cap_rw == RW_READ) && !flt) dout_q <= rd_dat;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_DONE: begin
          if (!bus.MOV) begin
            state   <= ST_IDLE;
            moc_q   <= 1'b0;
            fault_q <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.MOC   = moc_q;
  assign bus.fault = fault_q;
  assign bus.dout  = dout_q;

endmodule

// File: tb/tb_byte_ram_hs.sv
// Directed bench for byte_ram_hs: one instance with 2 wait states, one with none.
// Latency: checks MOC edge count after MOV capture.
// Backpressure: holds MOV after MOC to confirm a single access per request.
module tb_byte_ram_hs;

  logic CLK;
  logic CLR;

  int n_chk  = 0;
  int n_fail = 0;

  byte_ram_hs_if #(.ADDR_W(8)) bus2 ();
  byte_ram_hs_if #(.ADDR_W(8)) bus0 ();

  byte_ram_hs #(.DEPTH(256), .ADDR_W(8), .WAIT_CYCLES(2)) dut2 (
    .CLK (CLK),
    .CLR (CLR),
    .bus (bus2)
  );

  byte_ram_hs #(.DEPTH(256), .ADDR_W(8), .WAIT_CYCLES(0)) dut0 (
    .CLK (CLK),
    .CLR (CLR),
    .bus (bus0)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem2_word(input logic [7:0] a);
    logic [7:0] a1, a2, a3;
    a1 = a + 8'd1;
    a2 = a + 8'd2;
    a3 = a + 8'd3;
    return {dut2.mem[a], dut2.mem[a1], dut2.mem[a2], dut2.mem[a3]};
  endfunction

  task automatic drive(input int u, input logic mov, input logic rw, input logic [1:0] sz,
                       input logic [7:0] a, input logic [31:0] d);
    if (u == 2) begin
      bus2.MOV = mov; bus2.RW = rw; bus2.typeData = sz; bus2.addr = a; bus2.din = d;
    end else begin
      bus0.MOV = mov; bus0.RW = rw; bus0.typeData = sz; bus0.addr = a; bus0.din = d;
    end
  endtask

  // Raise MOV and wait (bounded) for MOC; lat counts edges after the capture edge.
  task automatic access(input int u, input logic rw, input logic [1:0] sz, input logic [7:0] a,
                        input logic [31:0] d, output int lat, output logic [31:0] dout_o,
                        output logic flt_o);
    int   edges;
    logic moc;
    @(negedge CLK);
    drive(u, 1'b1, rw, sz, a, d);
    edges = 0;
    moc   = 1'b0;
    while (!moc && edges < 40) begin
      @(posedge CLK);
      #1;
      edges++;
      moc = (u == 2) ? bus2.MOC : bus0.MOC;
    end
    check("moc_seen", {31'b0, moc}, 32'd1);
    lat    = edges - 1;
    dout_o = (u == 2) ? bus2.dout : bus0.dout;
    flt_o  = (u == 2) ? bus2.fault : bus0.fault;
  endtask

  task automatic release_mov(input int u, input string tag);
    @(negedge CLK);
    if (u == 2) bus2.MOV = 1'b0; else bus0.MOV = 1'b0;
    @(posedge CLK);
    #1;
    check({tag, "_moc_clr"}, {31'b0, (u == 2) ? bus2.MOC : bus0.MOC}, 32'd0);
    check({tag, "_flt_clr"}, {31'b0, (u == 2) ? bus2.fault : bus0.fault}, 32'd0);
  endtask

  initial begin
    int          lat;
    logic [31:0] dv;
    logic        fv;
    logic [31:0] exp_dout2;

    CLR = 1'b1;
    drive(2, 1'b0, 1'b1, 2'b00, 8'h00, 32'h0);
    drive(0, 1'b0, 1'b1, 2'b00, 8'h00, 32'h0);
    for (int i = 0; i < 256; i++) begin
      dut2.mem[i] = 8'h00;
      dut0.mem[i] = 8'h00;
    end
    dut2.mem[8'hFE] = 8'hAA;
    dut2.mem[8'hFF] = 8'hAA;
    dut2.mem[8'h00] = 8'hAA;
    dut2.mem[8'h01] = 8'hAA;

    // Reset state
    #2 CLR = 1'b0;
    #1;
    check("rst_moc", {31'b0, bus2.MOC}, 32'd0);
    check("rst_flt", {31'b0, bus2.fault}, 32'd0);
    check("rst_dout", bus2.dout, 32'd0);
    @(negedge CLK);
    @(negedge CLK);
    CLR = 1'b1;

    // Reset mid-BUSY discards the pending write to 0x10
    @(negedge CLK);
    drive(2, 1'b1, 1'b0, 2'b10, 8'h10, 32'hCAFEF00D);
    @(posedge CLK);
    @(posedge CLK);
    #1;
    CLR = 1'b0;
    #1;
    check("midrst_moc", {31'b0, bus2.MOC}, 32'd0);
    check("midrst_flt", {31'b0, bus2.fault}, 32'd0);
    check("midrst_dout", bus2.dout, 32'd0);
    bus2.MOV = 1'b0;
    @(negedge CLK);
    CLR = 1'b1;
    repeat (4) @(posedge CLK);
    #1;
    check("midrst_mem10", mem2_word(8'h10), 32'h00000000);

    // Word write / read at 0x04
    access(2, 1'b0, 2'b10, 8'h04, 32'hDEADBEEF, lat, dv, fv);
    check("wr4_lat", lat, 32'd3);
    check("wr4_flt", {31'b0, fv}, 32'd0);
    check("wr4_dout_hold", dv, 32'd0);
    release_mov(2, "wr4");
    check("wr4_mem", mem2_word(8'h04), 32'hDEADBEEF);

    access(2, 1'b1, 2'b10, 8'h04, 32'h0, lat, dv, fv);
    check("rd4_lat", lat, 32'd3);
    check("rd4_dout", dv, 32'hDEADBEEF);
    release_mov(2, "rd4");

    access(2, 1'b1, 2'b00, 8'h05, 32'h0, lat, dv, fv);
    check("rdb5_dout", dv, 32'h000000AD);
    release_mov(2, "rdb5");

    access(2, 1'b1, 2'b01, 8'h06, 32'h0, lat, dv, fv);
    check("rdh6_dout", dv, 32'h0000BEEF);
    release_mov(2, "rdh6");
    exp_dout2 = 32'h0000BEEF;

    // Wrapping word write at 0xFE
    access(2, 1'b0, 2'b10, 8'hFE, 32'h11223344, lat, dv, fv);
    check("wrFE_lat", lat, 32'd3);
`ifdef BYTE_RAM_ALIGN_CHK_EN
    check("wrFE_flt", {31'b0, fv}, 32'd1);
    release_mov(2, "wrFE");
    check("wrFE_mem", mem2_word(8'hFE), 32'hAAAAAAAA);
`else
    check("wrFE_flt", {31'b0, fv}, 32'd0);
    release_mov(2, "wrFE");
    check("wrFE_mem", mem2_word(8'hFE), 32'h11223344);
`endif

    access(2, 1'b1, 2'b10, 8'hFE, 32'h0, lat, dv, fv);
`ifdef BYTE_RAM_ALIGN_CHK_EN
    check("rdFE_flt", {31'b0, fv}, 32'd1);
    check("rdFE_dout", dv, 32'h0000BEEF);
`else
    check("rdFE_flt", {31'b0, fv}, 32'd0);
    check("rdFE_dout", dv, 32'h11223344);
    exp_dout2 = 32'h11223344;
`endif
    release_mov(2, "rdFE");

    // Reserved size: fault, dout held, MOC held while MOV stays high
    access(2, 1'b1, 2'b11, 8'h04, 32'h0, lat, dv, fv);
    check("rsv_lat", lat, 32'd3);
    check("rsv_flt", {31'b0, fv}, 32'd1);
    check("rsv_dout", dv, exp_dout2);
    for (int k = 0; k < 5; k++) begin
      @(posedge CLK);
      #1;
      check("rsv_hold_moc", {31'b0, bus2.MOC}, 32'd1);
    end
    check("rsv_hold_flt", {31'b0, bus2.fault}, 32'd1);
    release_mov(2, "rsv");

    // Held MOV with changing din must not cause a second write
    access(2, 1'b0, 2'b00, 8'h20, 32'h00000055, lat, dv, fv);
    for (int k = 0; k < 5; k++) begin
      @(negedge CLK);
      bus2.din = 32'h00000066;
    end
    @(posedge CLK);
    #1;
    check("hold_moc", {31'b0, bus2.MOC}, 32'd1);
    check("hold_mem20", {24'b0, dut2.mem[8'h20]}, 32'h00000055);
    release_mov(2, "hold");

    // Zero wait states, back-to-back requests
    access(0, 1'b0, 2'b00, 8'h30, 32'h0000005A, lat, dv, fv);
    check("w0_wr_lat", lat, 32'd1);
    release_mov(0, "w0wr");
    access(0, 1'b1, 2'b00, 8'h30, 32'h0, lat, dv, fv);
    check("w0_rd_lat", lat, 32'd1);
    check("w0_rd_dout", dv, 32'h0000005A);
    release_mov(0, "w0rd");
    access(0, 1'b0, 2'b01, 8'h32, 32'h00001234, lat, dv, fv);
    check("w0_wrh_lat", lat, 32'd1);
    release_mov(0, "w0wrh");
    access(0, 1'b1, 2'b01, 8'h32, 32'h0, lat, dv, fv);
    check("w0_rdh_dout", dv, 32'h00001234);
    check("w0_mem33", {24'b0, dut0.mem[8'h33]}, 32'h00000034);
    release_mov(0, "w0rdh");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
